// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the front-end pipeline controller: address bus width, redirect priority codes, FSM states.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package pipe_ctrl_pkg;

    localparam int ADDR_BUS_WIDTH = 32;

    typedef logic [ADDR_BUS_WIDTH-1:0] addr_bus_t;

    // Numeric order is the arbitration order: a larger code always wins.
    typedef enum logic [1:0] {
        RDR_NONE = 2'd0,
        RDR_BP   = 2'd1,
        RDR_MIS  = 2'd2,
        RDR_EXC  = 2'd3
    } rdr_prio_t;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_REDIRECT = 1'b1
    } ctrl_state_t;

    // Highest-priority redirect source raised this cycle.
    function automatic rdr_prio_t rdr_pick(input logic exc, input logic mis, input logic bp);
        rdr_prio_t p;
        if (exc)      p = RDR_EXC;
        else if (mis) p = RDR_MIS;
        else if (bp)  p = RDR_BP;
        else          p = RDR_NONE;
        return p;
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Bundle between the fetch pipeline (master) and pipe_ctrl (slave): stall requests, redirect sources, stage controls.
// Latency: n/a (wires only).
// Backpressure: redirect_ready from the PC stage holds redirect_valid/redirect_pc until accepted.
interface pipe_ctrl_if #(
    parameter int STAGE_NUM  = 5,
    parameter int ADDR_WIDTH = pipe_ctrl_pkg::ADDR_BUS_WIDTH
);
    logic [STAGE_NUM-1:0]  stall_req;
    logic                  exc_redirect;
    logic [ADDR_WIDTH-1:0] exc_target;
    logic                  mis_redirect;
    logic [ADDR_WIDTH-1:0] mis_target;
    logic                  bp_redirect;
    logic [ADDR_WIDTH-1:0] bp_target;
    logic                  redirect_ready;
    logic [STAGE_NUM-1:0]  stall;
    logic [STAGE_NUM-1:0]  flush;
    logic                  redirect_valid;
    logic [ADDR_WIDTH-1:0] redirect_pc;
    logic [31:0]           perf_stall_cnt;
    logic [31:0]           perf_flush_cnt;

    modport master (
        output stall_req, exc_redirect, exc_target, mis_redirect, mis_target,
               bp_redirect, bp_target, redirect_ready,
        input  stall, flush, redirect_valid, redirect_pc, perf_stall_cnt, perf_flush_cnt
    );

    modport slave (
        input  stall_req, exc_redirect, exc_target, mis_redirect, mis_target,
               bp_redirect, bp_target, redirect_ready,
        output stall, flush, redirect_valid, redirect_pc, perf_stall_cnt, perf_flush_cnt
    );
endinterface

// File: rtl/pipe_ctrl_perf_cnt.sv
// pipe_perf_cnt: two free-running 32-bit event counters (stall cycles, accepted redirects), wrapping to 0.
// Latency: count visible one cycle after the event.
// Backpressure: none; counts every cycle its event input is high.
module pipe_perf_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_evt_i,
    input  logic        flush_evt_i,
    output logic [31:0] stall_cnt_o,
    output logic [31:0] flush_cnt_o
);
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    // Increment on events; natural 32-bit overflow gives the wrap to 0.
    always_comb begin
        stall_cnt_d = stall_cnt_q + {31'd0, stall_evt_i};
        flush_cnt_d = flush_cnt_q + {31'd0, flush_evt_i};
    end

    // Counter registers, cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
endmodule

// File: rtl/pipe_ctrl.sv
// Front-end pipeline controller: per-stage stall/flush generation, redirect arbitration and pending-target hold.
// Latency: stall/flush combinational (0 cycles); redirect arrival at T -> redirect_valid at T+1. PIPE_CTRL_PERF_EN adds counters.
// Backpressure: pending redirect held (flush[0] asserted) until redirect_ready; higher/equal-priority arrivals replace it.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int STAGE_NUM     = 5,
    parameter int MISPRED_STAGE = 3,
    parameter int ADDR_WIDTH    = ADDR_BUS_WIDTH
) (
    input  logic clk,
    input  logic rst,
    pipe_ctrl_if.slave bus
);
    ctrl_state_t           state_q, state_d;
    rdr_prio_t             prio_q, prio_d;
    logic [ADDR_WIDTH-1:0] target_q, target_d;

    rdr_prio_t             win_prio;
    logic [ADDR_WIDTH-1:0] win_target;
    logic                  take_new;
    logic                  rdr_vld;
    logic                  squash;
    logic                  flush_exc, flush_mis, flush_bp;
    logic [STAGE_NUM-1:0]  flush_vec;
    logic [STAGE_NUM-1:0]  stall_vec;

    // Pick this cycle's redirect winner and its target.
    always_comb begin
        win_prio   = rdr_pick(bus.exc_redirect, bus.mis_redirect, bus.bp_redirect);
        win_target = '0;
        case (win_prio)
            RDR_EXC: win_target = bus.exc_target;
            RDR_MIS: win_target = bus.mis_target;
            RDR_BP:  win_target = bus.bp_target;
            default: win_target = '0;
        endcase
    end

    // A winner is taken when idle, or when it does not lose to the pending redirect.
    assign take_new = (win_prio != RDR_NONE) &&
                      ((state_q == ST_IDLE) || (win_prio >= prio_q));

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // FSM next state: a taken redirect always keeps us in REDIRECT, even if ready.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (take_new) state_d = ST_REDIRECT;
            ST_REDIRECT: begin
                if (take_new)                state_d = ST_REDIRECT;
                else if (bus.redirect_ready) state_d = ST_IDLE;
            end
            default:     state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: valid while pending, squash fetch, and flush scope of a taken redirect.
    always_comb begin
        rdr_vld   = (state_q == ST_REDIRECT);
        squash    = (state_q == ST_REDIRECT);
        flush_exc = take_new && (win_prio == RDR_EXC);
        flush_mis = take_new && (win_prio == RDR_MIS);
        flush_bp  = take_new && (win_prio == RDR_BP);
    end

    // Pending target/priority next-state: load on take, forget priority on acceptance.
    always_comb begin
        prio_d   = prio_q;
        target_d = target_q;
        if (take_new) begin
            prio_d   = win_prio;
            target_d = win_target;
        end else if (rdr_vld && bus.redirect_ready) begin
            prio_d   = RDR_NONE;
        end
    end

    // Pending redirect registers; reset discards anything in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_q   <= RDR_NONE;
            target_q <= '0;
        end else begin
            prio_q   <= prio_d;
            target_q <= target_d;
        end
    end

    // Per-stage vectors: a stall request stalls its stage and every younger-fetch
    // (lower index) stage; a flush on a stage cancels its stall.
    for (genvar i = 0; i < STAGE_NUM; i++) begin : g_stage
        localparam bit IN_MIS = (i < MISPRED_STAGE);
        localparam bit IS_PC  = (i == 0);
        assign flush_vec[i] = flush_exc | (flush_mis & IN_MIS) | ((flush_bp | squash) & IS_PC);
        assign stall_vec[i] = (|bus.stall_req[STAGE_NUM-1:i]) & ~flush_vec[i];
    end

    assign bus.stall          = stall_vec;
    assign bus.flush          = flush_vec;
    assign bus.redirect_valid = rdr_vld;
    assign bus.redirect_pc    = target_q;

`ifdef PIPE_CTRL_PERF_EN
    pipe_perf_cnt u_perf (
        .clk         (clk),
        .rst         (rst),
        .stall_evt_i (|stall_vec),
        .flush_evt_i (rdr_vld & bus.redirect_ready),
        .stall_cnt_o (bus.perf_stall_cnt),
        .flush_cnt_o (bus.perf_flush_cnt)
    );
`else
    assign bus.perf_stall_cnt = '0;
    assign bus.perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: table of stall/redirect vectors plus hand sequences for multi-cycle cases.
// Latency: inputs driven 1 ns after posedge, outputs sampled 4 ns after posedge.
// Backpressure: redirect_ready driven by the bench to accept pending redirects.
module tb_pipe_ctrl;
    localparam logic [31:0] EXC_PC = 32'hBFC0_0380;
    localparam logic [31:0] MIS_PC = 32'h8000_0100;
    localparam logic [31:0] BP_PC  = 32'h1000_0040;
    localparam logic [31:0] MIS_PC2 = 32'h8000_0200;
`ifdef PIPE_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipe_ctrl_if #(.STAGE_NUM(5), .ADDR_WIDTH(32)) bus ();

    pipe_ctrl #(.STAGE_NUM(5), .MISPRED_STAGE(3), .ADDR_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [4:0]  req;
        logic        exc;
        logic        mis;
        logic        bp;
        logic [4:0]  stall;
        logic [4:0]  flush;
        logic        rdr;
        logic [31:0] pc;
    } vec_t;

    vec_t vecs[10];
    int n_cmp = 0;
    int n_err = 0;
    int exp_stall_cyc = 0;
    int exp_flush_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        bus.stall_req    = '0;
        bus.exc_redirect = 1'b0;
        bus.mis_redirect = 1'b0;
        bus.bp_redirect  = 1'b0;
        bus.redirect_ready = 1'b0;
    endtask

    initial begin
        vecs[0] = '{5'b00100, 1'b0, 1'b0, 1'b0, 5'b00111, 5'b00000, 1'b0, 32'h0};
        vecs[1] = '{5'b00001, 1'b0, 1'b0, 1'b0, 5'b00001, 5'b00000, 1'b0, 32'h0};
        vecs[2] = '{5'b10000, 1'b0, 1'b0, 1'b0, 5'b11111, 5'b00000, 1'b0, 32'h0};
        vecs[3] = '{5'b00000, 1'b0, 1'b0, 1'b0, 5'b00000, 5'b00000, 1'b0, 32'h0};
        vecs[4] = '{5'b01000, 1'b0, 1'b0, 1'b1, 5'b01110, 5'b00001, 1'b1, BP_PC};
        vecs[5] = '{5'b00000, 1'b0, 1'b1, 1'b0, 5'b00000, 5'b00111, 1'b1, MIS_PC};
        vecs[6] = '{5'b00000, 1'b1, 1'b1, 1'b0, 5'b00000, 5'b11111, 1'b1, EXC_PC};
        vecs[7] = '{5'b11111, 1'b0, 1'b1, 1'b0, 5'b11000, 5'b00111, 1'b1, MIS_PC};
        vecs[8] = '{5'b00010, 1'b0, 1'b1, 1'b1, 5'b00000, 5'b00111, 1'b1, MIS_PC};
        vecs[9] = '{5'b10101, 1'b1, 1'b0, 1'b0, 5'b00000, 5'b11111, 1'b1, EXC_PC};

        clear_in();
        bus.exc_target = EXC_PC;
        bus.mis_target = MIS_PC;
        bus.bp_target  = BP_PC;

        // Reset state
        #12;
        chk("rst_valid", {31'd0, bus.redirect_valid}, 32'd0);
        chk("rst_pc", bus.redirect_pc, 32'd0);
        chk("rst_flush", {27'd0, bus.flush}, 32'd0);
        chk("rst_stall_cnt", bus.perf_stall_cnt, 32'd0);
        chk("rst_flush_cnt", bus.perf_flush_cnt, 32'd0);
        rst = 1'b0;

        // Table-driven vectors, each applied from IDLE for one cycle
        for (int i = 0; i < 10; i++) begin
            tick();
            bus.stall_req    = vecs[i].req;
            bus.exc_redirect = vecs[i].exc;
            bus.mis_redirect = vecs[i].mis;
            bus.bp_redirect  = vecs[i].bp;
            #3;
            chk($sformatf("v%0d_stall", i), {27'd0, bus.stall}, {27'd0, vecs[i].stall});
            chk($sformatf("v%0d_flush", i), {27'd0, bus.flush}, {27'd0, vecs[i].flush});
            chk($sformatf("v%0d_valid_T", i), {31'd0, bus.redirect_valid}, 32'd0);
            if (vecs[i].stall != 5'b0) exp_stall_cyc++;
            tick();
            clear_in();
            #3;
            chk($sformatf("v%0d_valid_T1", i), {31'd0, bus.redirect_valid}, {31'd0, vecs[i].rdr});
            if (vecs[i].rdr) begin
                chk($sformatf("v%0d_pc", i), bus.redirect_pc, vecs[i].pc);
                chk($sformatf("v%0d_squash", i), {27'd0, bus.flush}, 32'd1);
                bus.redirect_ready = 1'b1;
                exp_flush_cnt++;
                tick();
                bus.redirect_ready = 1'b0;
                #3;
                chk($sformatf("v%0d_idle", i), {31'd0, bus.redirect_valid}, 32'd0);
            end
        end

        // Mispredict with delayed acceptance: valid T+1..T+3, idle at T+4
        tick();
        bus.mis_redirect = 1'b1;
        #3;
        chk("mis_flush_T", {27'd0, bus.flush}, 32'b00111);
        tick();
        bus.mis_redirect = 1'b0;
        #3;
        chk("mis_valid_T1", {31'd0, bus.redirect_valid}, 32'd1);
        chk("mis_pc_T1", bus.redirect_pc, MIS_PC);
        tick();
        #3;
        chk("mis_valid_T2", {31'd0, bus.redirect_valid}, 32'd1);
        tick();
        bus.redirect_ready = 1'b1;
        exp_flush_cnt++;
        #3;
        chk("mis_valid_T3", {31'd0, bus.redirect_valid}, 32'd1);
        tick();
        bus.redirect_ready = 1'b0;
        #3;
        chk("mis_idle_T4", {31'd0, bus.redirect_valid}, 32'd0);
        chk("mis_flush_cnt", bus.perf_flush_cnt, PERF ? exp_flush_cnt : 32'd0);

        // Pending MIS: lower BP ignored, then EXC with ready replaces and stays
        tick();
        bus.mis_redirect = 1'b1;
        tick();
        bus.mis_redirect = 1'b0;
        bus.bp_redirect  = 1'b1;
        #3;
        chk("bp_ign_flush", {27'd0, bus.flush}, 32'b00001);
        tick();
        bus.bp_redirect = 1'b0;
        #3;
        chk("bp_ign_pc", bus.redirect_pc, MIS_PC);
        bus.exc_redirect   = 1'b1;
        bus.redirect_ready = 1'b1;
        exp_flush_cnt++;
        #1;
        chk("exc_rep_flush", {27'd0, bus.flush}, 32'b11111);
        tick();
        bus.exc_redirect   = 1'b0;
        bus.redirect_ready = 1'b0;
        #3;
        chk("exc_rep_valid", {31'd0, bus.redirect_valid}, 32'd1);
        chk("exc_rep_pc", bus.redirect_pc, EXC_PC);
        bus.redirect_ready = 1'b1;
        exp_flush_cnt++;
        tick();
        bus.redirect_ready = 1'b0;
        #3;
        chk("exc_rep_idle", {31'd0, bus.redirect_valid}, 32'd0);

        // Equal priority replaces the pending target
        tick();
        bus.mis_redirect = 1'b1;
        tick();
        bus.mis_target = MIS_PC2;
        #3;
        chk("mis_rep_flush", {27'd0, bus.flush}, 32'b00111);
        tick();
        bus.mis_redirect = 1'b0;
        bus.mis_target   = MIS_PC;
        #3;
        chk("mis_rep_pc", bus.redirect_pc, MIS_PC2);
        bus.redirect_ready = 1'b1;
        exp_flush_cnt++;
        tick();
        bus.redirect_ready = 1'b0;
        #3;
        chk("mis_rep_idle", {31'd0, bus.redirect_valid}, 32'd0);
        chk("perf_stall", bus.perf_stall_cnt, PERF ? exp_stall_cyc : 32'd0);
        chk("perf_flush", bus.perf_flush_cnt, PERF ? exp_flush_cnt : 32'd0);

        // Reset mid-REDIRECT discards the pending redirect
        tick();
        bus.mis_redirect = 1'b1;
        tick();
        bus.mis_redirect = 1'b0;
        #3;
        chk("rst_mid_pre", {31'd0, bus.redirect_valid}, 32'd1);
        bus.redirect_ready = 1'b1;
        rst = 1'b1;
        #1;
        chk("rst_mid_valid", {31'd0, bus.redirect_valid}, 32'd0);
        chk("rst_mid_pc", bus.redirect_pc, 32'd0);
        chk("rst_mid_scnt", bus.perf_stall_cnt, 32'd0);
        chk("rst_mid_fcnt", bus.perf_flush_cnt, 32'd0);
        tick();
        rst = 1'b0;
        bus.redirect_ready = 1'b0;
        tick();
        #3;
        chk("post_rst_valid", {31'd0, bus.redirect_valid}, 32'd0);
        chk("post_rst_fcnt", bus.perf_flush_cnt, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
